fwd_hazard_unit: RTL and testbench
==================================

# fwd_hazard_unit

Parametrised, registered operand-forwarding and load-use hazard controller for the RV32I in-order pipeline. It decodes the instruction in ID and keeps a shift register of destination records for the DEPTH downstream stages (EX, MEM, WB, …). It raises a load-use stall when the youngest producer of a needed source is not yet ready. At issue it registers the per-operand forwarding selects that steer the EX-stage operand muxes. A saturating counter reports load-use stall cycles.

## Interface
- DEPTH, 3: tracked stages after ID (EX=0 … WB=DEPTH-1). Minimum 2.
- LOAD_LAT, 1: extra stages after EX before load data is forwardable. Range 1 ≤ LOAD_LAT ≤ DEPTH-1.
- CNT_W, 16: width of the stall counter.
- SELW, derived as $clog2(DEPTH): width of the forward selects.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- id_valid_i  in  1  ID slot holds a real instruction
- id_inst_i  in  32  instruction word in ID
- stall_ext_i  in  1  global pipeline freeze (memory wait, etc.)
- flush_i  in  1  kill the ID instruction (redirect resolved in EX)
- stall_o  out  1  combinational load-use stall: hold PC/ID, insert a bubble into EX
- fwd_sel_rs1_o  out  SELW  registered rs1 select for the EX instruction: 0 = regfile, k = stage-k result (1 = MEM, 2 = WB at DEPTH=3)
- fwd_sel_rs2_o  out  SELW  same encoding, for rs2
- ex_valid_o  out  1  EX slot holds a real (non-bubble) instruction
- stall_cnt_o  out  CNT_W  saturating count of cycles where stall_o is high

## Operation
- **Decode of id_inst_i[6:0].**
  - rs1 used by R (0110011), I-ALU (0010011), LOAD (0000011), STORE (0100011), BRANCH (1100011), JALR (1100111).
  - rs2 used by R, STORE, BRANCH.
  - Writes rd for R, I-ALU, LOAD, LUI (0110111), AUIPC (0010111), JAL (1101111), JALR, and only when rd != 0.
  - Any other opcode uses no sources and writes nothing.
- **Record contents.** Each record rec[j], j = 0..DEPTH-1, holds {valid, rd[4:0], is_load}. rec[0] is the instruction now in EX.
- **Distance.** After the next advance, rec[j] sits at distance d = j+1 from the issuing instruction.
- **Readiness.**
  - A non-load producer is ready at d ≥ 1.
  - A load producer is ready at d ≥ 1+LOAD_LAT.
  - A producer at d ≥ DEPTH has retired and its value is read from the regfile (select 0).
- **Select per used source rs.**
  - Find the smallest j ≤ DEPTH-2 with rec[j].valid and rec[j].rd == rs, rs != 0.
  - No match, an unused source, or rs == 0 gives select 0.
  - A match gives select j+1.
- **Stall.**
  - stall_o = id_valid_i & !flush_i & (some used source's youngest match is a load that is not ready).
  - Only the youngest match is considered; an older ready match never masks a younger unready one.
- **Advance.** An advance happens on each rising clk edge with stall_ext_i = 0. On an advance:
  - rec[j+1] <= rec[j]; the oldest record drops.
  - rec[0] <= decoded ID record if id_valid_i & !flush_i & !stall_o, else a bubble (valid = 0).
  - fwd_sel_*_o <= computed selects when a real instruction is inserted, else 0.
  - ex_valid_o <= the valid bit of the new rec[0].
  - stall_cnt_o increments when stall_o = 1 and saturates at all-ones.
- **Freeze.** With stall_ext_i = 1, all records and registered outputs hold, and stall_cnt_o does not count. stall_o still reflects the held state.
- **Priority.**
  - stall_ext_i over everything.
  - flush_i over the load-use stall: a flushed ID raises no stall and inserts a bubble.

## Timing
- **Reset.** While rst_n = 0, all records are invalid and fwd_sel_rs1_o = fwd_sel_rs2_o = 0, ex_valid_o = 0, stall_cnt_o = 0. stall_o is therefore 0. Reset asserted mid-stall takes effect immediately, without waiting for clk.
- **Select latency.** Selects are computed in the ID cycle and are visible on the outputs for exactly the cycle the instruction occupies EX.
- **stall_o latency.** stall_o is combinational, valid in the same cycle as id_inst_i.
- **Stall duration.** A load-use stall lasts LOAD_LAT+1-d cycles, where d is the producer's distance, not counting frozen cycles. With the default parameters, a back-to-back dependent instruction stalls 1 cycle.
- **Bubbles.** Each stall cycle inserts one bubble. The stalled instruction re-evaluates every cycle against the shifted records.

## Test plan
- **Back-to-back ALU dependency.** `add x5,x1,x2`, then `add x6,x5,x1` -> the second instruction's EX cycle shows fwd_sel_rs1_o=1, fwd_sel_rs2_o=0, stall_o never 1.
- **Two-apart store.** `addi x5,x0,4`; `nop`; `sw x5,0(x5)` -> in the store's EX cycle, rs1 and rs2 selects are both 2.
- **Load-use (DEPTH=3, LOAD_LAT=1).** `lw x7,0(x1)`, then `add x8,x7,x7` -> stall_o=1 for 1 cycle and ex_valid_o=0 in the bubble cycle. The add then reaches EX with both selects 2, and stall_cnt_o=1.
- **x0 and youngest-wins.** `addi x0,x0,1` then `add x1,x0,x0` -> both selects 0. `add x5`, `addi x5`, `or x9,x5,x0` -> rs1 select 1.
- **Freeze and flush during a stall.** Hold stall_ext_i for 3 cycles during a load-use stall -> outputs and counter are unchanged. Then pulse flush_i -> stall_o=0 and a bubble is inserted.
- **Async reset.** Assert rst_n mid-stall, with no clk edge -> all outputs 0 immediately. Counter saturation (CNT_W=2): 5 stall cycles -> stall_cnt_o=3.

Source files
------------

// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - RV32I operand-forwarding select and load-use hazard controller
module fwd_hazard_unit #(
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16,
    localparam int SELW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid_i,
    input  logic [31:0]      id_inst_i,
    input  logic             stall_ext_i,
    input  logic             flush_i,
    output logic             stall_o,
    output logic [SELW-1:0]  fwd_sel_rs1_o,
    output logic [SELW-1:0]  fwd_sel_rs2_o,
    output logic             ex_valid_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    logic [DEPTH-1:0] rec_valid;
    logic [DEPTH-1:0] rec_load;
    logic [4:0]       rec_rd [DEPTH];

    logic [6:0] opcode;
    logic [4:0] rd, rs1, rs2;
    logic       use_rs1, use_rs2, writes_rd, is_load;
    logic [SELW-1:0] sel_rs1, sel_rs2;
    logic       haz_rs1, haz_rs2;
    logic       insert;

    assign opcode = id_inst_i[6:0];
    assign rd     = id_inst_i[11:7];
    assign rs1    = id_inst_i[19:15];
    assign rs2    = id_inst_i[24:20];

    always_comb begin
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        writes_rd = 1'b0;
        is_load   = 1'b0;
        case (opcode)
            OP_R: begin
                use_rs1   = 1'b1;
                use_rs2   = 1'b1;
                writes_rd = 1'b1;
            end
            OP_I_ALU, OP_JALR: begin
                use_rs1   = 1'b1;
                writes_rd = 1'b1;
            end
            OP_LOAD: begin
                use_rs1   = 1'b1;
                writes_rd = 1'b1;
                is_load   = 1'b1;
            end
            OP_STORE, OP_BRANCH: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OP_LUI, OP_AUIPC, OP_JAL: writes_rd = 1'b1;
            default: ;
        endcase
        if (rd == 5'd0) begin
            writes_rd = 1'b0;
            is_load   = 1'b0;
        end
    end

    // Scan oldest-to-youngest so the youngest match (smallest j) wins;
    // the oldest record has already retired to the regfile and is skipped.
    always_comb begin
        sel_rs1 = '0;
        sel_rs2 = '0;
        haz_rs1 = 1'b0;
        haz_rs2 = 1'b0;
        for (int j = DEPTH - 2; j >= 0; j--) begin
            if (use_rs1 && rs1 != 5'd0 && rec_valid[j] && rec_rd[j] == rs1) begin
                sel_rs1 = SELW'(j + 1);
                haz_rs1 = rec_load[j] && (j < LOAD_LAT);
            end
            if (use_rs2 && rs2 != 5'd0 && rec_valid[j] && rec_rd[j] == rs2) begin
                sel_rs2 = SELW'(j + 1);
                haz_rs2 = rec_load[j] && (j < LOAD_LAT);
            end
        end
    end

    assign stall_o = id_valid_i & ~flush_i & (haz_rs1 | haz_rs2);
    assign insert  = id_valid_i & ~flush_i & ~stall_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rec_valid     <= '0;
            rec_load      <= '0;
            for (int j = 0; j < DEPTH; j++) begin
                rec_rd[j] <= 5'd0;
            end
            fwd_sel_rs1_o <= '0;
            fwd_sel_rs2_o <= '0;
            ex_valid_o    <= 1'b0;
            stall_cnt_o   <= '0;
        end else if (!stall_ext_i) begin
            for (int j = DEPTH - 1; j >= 1; j--) begin
                rec_valid[j] <= rec_valid[j-1];
                rec_load[j]  <= rec_load[j-1];
                rec_rd[j]    <= rec_rd[j-1];
            end
            // Non-writing instructions keep rd=0 so they never match a source.
            rec_valid[0]  <= insert;
            rec_load[0]   <= insert & is_load;
            rec_rd[0]     <= (insert && writes_rd) ? rd : 5'd0;
            fwd_sel_rs1_o <= insert ? sel_rs1 : '0;
            fwd_sel_rs2_o <= insert ? sel_rs2 : '0;
            ex_valid_o    <= insert;
            if (stall_o && stall_cnt_o != {CNT_W{1'b1}}) begin
                stall_cnt_o <= stall_cnt_o + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb/tb_fwd_hazard_unit.sv - bench for fwd_hazard_unit against an age-based issue-history model
module tb_fwd_hazard_unit;

    localparam int DEPTH    = 3;
    localparam int LOAD_LAT = 1;
    localparam int SELW     = $clog2(DEPTH);

    localparam logic [6:0] R   = 7'b0110011;
    localparam logic [6:0] IA  = 7'b0010011;
    localparam logic [6:0] LD  = 7'b0000011;
    localparam logic [6:0] ST  = 7'b0100011;
    localparam logic [6:0] BR  = 7'b1100011;
    localparam logic [6:0] JR  = 7'b1100111;
    localparam logic [6:0] LUI = 7'b0110111;
    localparam logic [6:0] AUI = 7'b0010111;
    localparam logic [6:0] JAL = 7'b1101111;
    localparam logic [6:0] SYS = 7'b1110011;

    logic clk = 1'b0;
    logic rst_n;
    logic id_valid;
    logic [31:0] id_inst;
    logic stall_ext;
    logic flush;
    logic stall_a, stall_b;
    logic [SELW-1:0] sel1_a, sel2_a, sel1_b, sel2_b;
    logic exv_a, exv_b;
    logic [15:0] cnt_a;
    logic [1:0]  cnt_b;

    always #5 clk = ~clk;

    fwd_hazard_unit #(.DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .id_valid_i(id_valid), .id_inst_i(id_inst),
        .stall_ext_i(stall_ext), .flush_i(flush), .stall_o(stall_a),
        .fwd_sel_rs1_o(sel1_a), .fwd_sel_rs2_o(sel2_a), .ex_valid_o(exv_a),
        .stall_cnt_o(cnt_a)
    );

    fwd_hazard_unit #(.DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .id_valid_i(id_valid), .id_inst_i(id_inst),
        .stall_ext_i(stall_ext), .flush_i(flush), .stall_o(stall_b),
        .fwd_sel_rs1_o(sel1_b), .fwd_sel_rs2_o(sel2_b), .ex_valid_o(exv_b),
        .stall_cnt_o(cnt_b)
    );

    typedef struct {
        logic [4:0] rd;
        bit         load;
        int         k;
    } item_t;

    item_t q[$];
    int    n_adv;
    int    exp_sel1, exp_sel2, exp_cnt;
    bit    exp_exv;
    logic  last_stall;
    int    checks = 0;
    int    errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic [6:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b0, rd, op};
    endfunction

    // Age = advances since the producer entered EX; youngest producer = largest k.
    function automatic void lookup(input logic [4:0] rs, input bit used,
                                   output int sel, output bit haz);
        int best;
        sel  = 0;
        haz  = 1'b0;
        best = -1;
        if (!used || rs == 5'd0) return;
        foreach (q[i]) begin
            int age;
            age = n_adv - q[i].k;
            if (age <= DEPTH - 2 && q[i].rd == rs && q[i].k > best) begin
                best = q[i].k;
                sel  = age + 1;
                haz  = q[i].load && (age + 1 < 1 + LOAD_LAT);
            end
        end
    endfunction

    function automatic int min3(input int v);
        return (v > 3) ? 3 : v;
    endfunction

    task automatic model_reset();
        q.delete();
        n_adv    = 0;
        exp_sel1 = 0;
        exp_sel2 = 0;
        exp_cnt  = 0;
        exp_exv  = 1'b0;
    endtask

    task automatic chk_regs(input string tag);
        chk({tag, "_sel1"}, 32'(sel1_a), exp_sel1);
        chk({tag, "_sel2"}, 32'(sel2_a), exp_sel2);
        chk({tag, "_exv"}, 32'(exv_a), 32'(exp_exv));
        chk({tag, "_cnt"}, 32'(cnt_a), exp_cnt);
        chk({tag, "_cnt_sat"}, 32'(cnt_b), min3(exp_cnt));
        chk({tag, "_sel1_b"}, 32'(sel1_b), exp_sel1);
    endtask

    task automatic step(input logic v, input logic [31:0] inst, input logic se, input logic fl);
        logic [6:0] op;
        logic [4:0] rd;
        bit u1, u2, wr, ld, h1, h2, exp_stall, ins;
        int s1, s2;
        id_valid  = v;
        id_inst   = inst;
        stall_ext = se;
        flush     = fl;
        #1;
        op = inst[6:0];
        rd = inst[11:7];
        u1 = op inside {R, IA, LD, ST, BR, JR};
        u2 = op inside {R, ST, BR};
        wr = (op inside {R, IA, LD, LUI, AUI, JAL, JR}) && rd != 5'd0;
        ld = (op == LD);
        lookup(inst[19:15], u1, s1, h1);
        lookup(inst[24:20], u2, s2, h2);
        exp_stall  = v && !fl && (h1 || h2);
        last_stall = stall_a;
        chk("stall_o", 32'(stall_a), 32'(exp_stall));
        chk("stall_o_b", 32'(stall_b), 32'(exp_stall));
        @(posedge clk);
        #1;
        if (!se) begin
            n_adv++;
            ins = v && !fl && !exp_stall;
            if (ins && wr) q.push_back('{rd: rd, load: ld, k: n_adv});
            while (q.size() > 0 && n_adv - q[0].k > DEPTH) void'(q.pop_front());
            exp_sel1 = ins ? s1 : 0;
            exp_sel2 = ins ? s2 : 0;
            exp_exv  = ins;
            if (exp_stall) exp_cnt++;
        end
        chk_regs("post");
    endtask

    initial begin
        logic [6:0] ops [10];
        ops = '{R, IA, LD, ST, BR, JR, LUI, AUI, JAL, SYS};
        model_reset();
        rst_n     = 1'b0;
        id_valid  = 1'b0;
        id_inst   = 32'd0;
        stall_ext = 1'b0;
        flush     = 1'b0;
        #3;
        chk_regs("reset");
        chk("reset_stall", 32'(stall_a), 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // back-to-back ALU dependency
        step(1, enc(R, 5, 1, 2), 0, 0);
        step(1, enc(R, 6, 5, 1), 0, 0);
        chk("b2b_stall", 32'(last_stall), 0);
        chk("b2b_sel1", 32'(sel1_a), 1);
        chk("b2b_sel2", 32'(sel2_a), 0);

        // two-apart store
        step(1, enc(IA, 5, 0, 4), 0, 0);
        step(1, enc(IA, 0, 0, 0), 0, 0);
        step(1, enc(ST, 0, 5, 5), 0, 0);
        chk("st_sel1", 32'(sel1_a), 2);
        chk("st_sel2", 32'(sel2_a), 2);

        // load-use
        step(1, enc(LD, 7, 1, 0), 0, 0);
        step(1, enc(R, 8, 7, 7), 0, 0);
        chk("lu_stall", 32'(last_stall), 1);
        chk("lu_bubble", 32'(exv_a), 0);
        step(1, enc(R, 8, 7, 7), 0, 0);
        chk("lu_stall_end", 32'(last_stall), 0);
        chk("lu_sel1", 32'(sel1_a), 2);
        chk("lu_sel2", 32'(sel2_a), 2);
        chk("lu_cnt", 32'(cnt_a), 1);

        // x0 and youngest-wins
        step(1, enc(IA, 0, 0, 1), 0, 0);
        step(1, enc(R, 1, 0, 0), 0, 0);
        chk("x0_sel1", 32'(sel1_a), 0);
        chk("x0_sel2", 32'(sel2_a), 0);
        step(1, enc(R, 5, 1, 2), 0, 0);
        step(1, enc(IA, 5, 5, 1), 0, 0);
        step(1, enc(R, 9, 5, 0), 0, 0);
        chk("young_sel1", 32'(sel1_a), 1);

        // freeze then flush during a stall
        step(1, enc(LD, 3, 1, 0), 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, enc(R, 4, 3, 0), 1, 0);
            chk("frz_stall", 32'(last_stall), 1);
            chk("frz_exv", 32'(exv_a), 1);
            chk("frz_cnt", 32'(cnt_a), 1);
        end
        step(1, enc(R, 4, 3, 0), 0, 1);
        chk("flush_stall", 32'(last_stall), 0);
        chk("flush_bubble", 32'(exv_a), 0);

        // randomized traffic over a small register pool
        for (int i = 0; i < 600; i++) begin
            logic [31:0] inst;
            inst = enc(ops[$urandom_range(0, 9)], 5'($urandom_range(0, 3)),
                       5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
            step(($urandom_range(0, 99) < 85), inst,
                 ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 10));
        end

        // async reset in the middle of a load-use stall
        repeat (3) step(0, 32'd0, 0, 0);
        step(1, enc(LD, 2, 1, 0), 0, 0);
        id_valid = 1'b1;
        id_inst  = enc(R, 3, 2, 2);
        #1;
        chk("ar_pre_stall", 32'(stall_a), 1);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("ar_stall", 32'(stall_a), 0);
        chk_regs("async_rst");
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(1, enc(LD, 2, 1, 0), 0, 0);
        step(1, enc(R, 3, 2, 2), 0, 0);
        step(1, enc(R, 3, 2, 2), 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
